// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
//   state_t           : arbiter FSM states (IDLE, ACCESS, RESP)
//   GNT_NONE/CPU/DMA  : encoding of the 2-bit grant / owner field
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned GNT_W = 2;

    localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
    localparam logic [GNT_W-1:0] GNT_CPU  = 2'b01;
    localparam logic [GNT_W-1:0] GNT_DMA  = 2'b10;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-ported memory.
// Each access takes two cycles: ACCESS drives the memory bus, RESP pulses
// the owner's ready with read data already in the owner's rd register.
// mem_rd is sampled on the edge that ends ACCESS, i.e. one cycle after the
// registered address was launched, so rd and ready appear together in RESP.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wd         CPU request (held until cpu_ready)
//   cpu_rd, cpu_ready          CPU read data register, completion pulse
//   dma_req/we/addr/wd         DMA request (held until dma_ready)
//   dma_rd, dma_ready          DMA read data register, completion pulse
//   mem_we/addr/wd             memory write strobe, address, write data
//   mem_rd                     memory read data
//   grant                      current owner (GNT_NONE/GNT_CPU/GNT_DMA)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned CPU_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wd,
    output logic [DW-1:0]    cpu_rd,
    output logic             cpu_ready,

    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [AW-1:0]    dma_addr,
    input  logic [DW-1:0]    dma_wd,
    output logic [DW-1:0]    dma_rd,
    output logic             dma_ready,

    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wd,
    input  logic [DW-1:0]    mem_rd,

    output logic [GNT_W-1:0] grant
);

    localparam bit ROUND_ROBIN = (CPU_PRIO == 0);

    state_t             state_q;
    state_t             state_d;
    logic [GNT_W-1:0]   grant_d;
    logic               last_dma;   // 1: DMA was the last port to enter ACCESS
    logic               start;      // entering ACCESS on the next edge
    logic               pick_dma;   // winner of the access being started

    // Next-state, owner selection and arbitration
    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        start    = 1'b0;
        pick_dma = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = GNT_NONE;
                if (cpu_req || dma_req) begin
                    start = 1'b1;
                    // Tie: round-robin favours the port not granted last,
                    // fixed priority always favours the CPU.
                    pick_dma = dma_req && (!cpu_req || (ROUND_ROBIN && !last_dma));
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // The port just served is ineligible; only the other may chain.
                state_d = IDLE;
                grant_d = GNT_NONE;
                if ((grant == GNT_CPU) && dma_req) begin
                    start    = 1'b1;
                    pick_dma = 1'b1;
                end else if ((grant == GNT_DMA) && cpu_req) begin
                    start    = 1'b1;
                    pick_dma = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase

        if (start) begin
            state_d = ACCESS;
            grant_d = pick_dma ? GNT_DMA : GNT_CPU;
        end
    end

    // State, memory bus and per-port response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant     <= GNT_NONE;
            last_dma  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            cpu_rd    <= '0;
            dma_rd    <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            mem_we  <= start && (pick_dma ? dma_we : cpu_we);

            // Bus fields only move when a new access launches.
            if (start) begin
                last_dma <= pick_dma;
                mem_addr <= pick_dma ? dma_addr : cpu_addr;
                mem_wd   <= pick_dma ? dma_wd   : cpu_wd;
            end

            cpu_ready <= (state_q == ACCESS) && (grant == GNT_CPU);
            dma_ready <= (state_q == ACCESS) && (grant == GNT_DMA);

            // mem_we is the latched direction of the access in flight, so a
            // dropped or changed request cannot alter the completion.
            if ((state_q == ACCESS) && !mem_we) begin
                if (grant == GNT_CPU) cpu_rd <= mem_rd;
                if (grant == GNT_DMA) dma_rd <= mem_rd;
            end
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority
// instance share one stimulus; each has its own small memory model whose
// read data follows the registered mem_addr.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          mem_init;

    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wd, dma_wd;

    logic [DW-1:0] rr_cpu_rd, rr_dma_rd, rr_mem_wd, rr_mem_rd;
    logic          rr_cpu_ready, rr_dma_ready, rr_mem_we;
    logic [AW-1:0] rr_mem_addr;
    logic [1:0]    rr_grant;

    logic [DW-1:0] fp_cpu_rd, fp_dma_rd, fp_mem_wd, fp_mem_rd;
    logic          fp_cpu_ready, fp_dma_ready, fp_mem_we;
    logic [AW-1:0] fp_mem_addr;
    logic [1:0]    fp_grant;

    logic [DW-1:0] mem_rr [256];
    logic [DW-1:0] mem_fp [256];

    int n_vec;
    int n_err;

    mem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(rr_cpu_rd), .cpu_ready(rr_cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_rd(rr_dma_rd), .dma_ready(rr_dma_ready),
        .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_wd(rr_mem_wd),
        .mem_rd(rr_mem_rd), .grant(rr_grant)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(fp_cpu_rd), .cpu_ready(fp_cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_rd(fp_dma_rd), .dma_ready(fp_dma_ready),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wd(fp_mem_wd),
        .mem_rd(fp_mem_rd), .grant(fp_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rr_mem_rd = mem_rr[rr_mem_addr[7:0]];
    assign fp_mem_rd = mem_fp[fp_mem_addr[7:0]];

    // Memory models: preload while mem_init is high, then accept writes.
    always @(posedge clk) begin
        if (mem_init) begin
            mem_rr[8'h10] <= 32'hDEAD_BEEF;
            mem_rr[8'h20] <= 32'h0000_0000;
            mem_rr[8'h30] <= 32'h0BAD_F00D;
            mem_rr[8'h40] <= 32'h0000_0000;
            mem_fp[8'h10] <= 32'hDEAD_BEEF;
            mem_fp[8'h20] <= 32'h0000_0000;
            mem_fp[8'h30] <= 32'h0BAD_F00D;
            mem_fp[8'h40] <= 32'h0000_0000;
        end else begin
            if (rr_mem_we) mem_rr[rr_mem_addr[7:0]] <= rr_mem_wd;
            if (fp_mem_we) mem_fp[fp_mem_addr[7:0]] <= fp_mem_wd;
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        mem_init = 1'b1;
        cpu_req  = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
        dma_req  = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wd = '0;

        // Reset values
        repeat (3) tick();
        check_vec("rst_grant",     64'(rr_grant),     64'h0);
        check_vec("rst_mem_we",    64'(rr_mem_we),    64'h0);
        check_vec("rst_mem_addr",  64'(rr_mem_addr),  64'h0);
        check_vec("rst_mem_wd",    64'(rr_mem_wd),    64'h0);
        check_vec("rst_cpu_rd",    64'(rr_cpu_rd),    64'h0);
        check_vec("rst_dma_rd",    64'(rr_dma_rd),    64'h0);
        check_vec("rst_cpu_ready", 64'(rr_cpu_ready), 64'h0);
        check_vec("rst_dma_ready", 64'(rr_dma_ready), 64'h0);
        reset    = 1'b1;
        mem_init = 1'b0;
        tick();
        check_vec("idle_grant", 64'(rr_grant), 64'h0);

        // Single CPU read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        check_vec("rd_acc_grant",  64'(rr_grant),     64'h1);
        check_vec("rd_acc_addr",   64'(rr_mem_addr),  64'h10);
        check_vec("rd_acc_we",     64'(rr_mem_we),    64'h0);
        check_vec("rd_acc_ready",  64'(rr_cpu_ready), 64'h0);
        tick();
        check_vec("rd_resp_ready", 64'(rr_cpu_ready), 64'h1);
        check_vec("rd_resp_data",  64'(rr_cpu_rd),    64'hDEAD_BEEF);
        check_vec("rd_resp_grant", 64'(rr_grant),     64'h1);
        check_vec("rd_resp_dma",   64'(rr_dma_ready), 64'h0);
        cpu_req = 1'b0;
        tick();
        check_vec("rd_idle_ready", 64'(rr_cpu_ready), 64'h0);
        check_vec("rd_idle_grant", 64'(rr_grant),     64'h0);
        check_vec("rd_idle_dma",   64'(rr_dma_ready), 64'h0);

        // CPU write 0x1234 to 0x20
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wd = 32'h1234;
        tick();
        check_vec("wr_acc_we",    64'(rr_mem_we),   64'h1);
        check_vec("wr_acc_addr",  64'(rr_mem_addr), 64'h20);
        check_vec("wr_acc_wd",    64'(rr_mem_wd),   64'h1234);
        tick();
        check_vec("wr_resp_we",    64'(rr_mem_we),    64'h0);
        check_vec("wr_resp_ready", 64'(rr_cpu_ready), 64'h1);
        check_vec("wr_resp_rd",    64'(rr_cpu_rd),    64'hDEAD_BEEF);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check_vec("wr_idle_we",   64'(rr_mem_we),     64'h0);
        check_vec("wr_hold_addr", 64'(rr_mem_addr),   64'h20);
        check_vec("wr_hold_wd",   64'(rr_mem_wd),     64'h1234);
        check_vec("wr_mem",       64'(mem_rr[8'h20]), 64'h1234);

        // Both ports request continuously from reset
        pulse_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30;
        begin
            logic [1:0] seq [8];
            seq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
            for (int i = 0; i < 8; i++) begin
                tick();
                check_vec($sformatf("both_rr_%0d", i), 64'(rr_grant), 64'(seq[i]));
                check_vec($sformatf("both_fp_%0d", i), 64'(fp_grant), 64'(seq[i]));
            end
        end
        check_vec("both_dma_ready", 64'(rr_dma_ready), 64'h1);
        check_vec("both_dma_rd",    64'(rr_dma_rd),    64'h0BAD_F00D);
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
        check_vec("both_idle_rr", 64'(rr_grant), 64'h0);
        check_vec("both_idle_fp", 64'(fp_grant), 64'h0);

        // Tie after a lone CPU access: round-robin picks DMA, fixed picks CPU
        cpu_req = 1'b1;
        tick();
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; dma_req = 1'b1;
        tick();
        check_vec("tie_rr_grant", 64'(rr_grant), 64'h2);
        check_vec("tie_fp_grant", 64'(fp_grant), 64'h1);
        tick();
        check_vec("tie_rr_dma_ready", 64'(rr_dma_ready), 64'h1);
        check_vec("tie_fp_cpu_ready", 64'(fp_cpu_ready), 64'h1);
        tick();
        check_vec("tie_rr_next", 64'(rr_grant), 64'h1);
        check_vec("tie_fp_next", 64'(fp_grant), 64'h2);
        // Requests dropped mid-access: completion still occurs
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
        check_vec("drop_rr_cpu_ready", 64'(rr_cpu_ready), 64'h1);
        check_vec("drop_fp_dma_ready", 64'(fp_dma_ready), 64'h1);
        check_vec("drop_fp_dma_rd",    64'(fp_dma_rd),    64'h0BAD_F00D);
        check_vec("drop_fp_cpu_rd",    64'(fp_cpu_rd),    64'hDEAD_BEEF);
        tick();
        check_vec("drop_rr_idle", 64'(rr_grant), 64'h0);
        check_vec("drop_fp_idle", 64'(fp_grant), 64'h0);

        // Reset during the ACCESS of a DMA write
        pulse_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wd = 32'hCAFE_0001;
        tick();
        check_vec("rst_acc_we",    64'(rr_mem_we), 64'h1);
        check_vec("rst_acc_grant", 64'(rr_grant),  64'h2);
        reset = 1'b0;
        #1;
        check_vec("async_we",    64'(rr_mem_we),   64'h0);
        check_vec("async_grant", 64'(rr_grant),    64'h0);
        check_vec("async_addr",  64'(rr_mem_addr), 64'h0);
        tick();
        check_vec("async_no_ready", 64'(rr_dma_ready),  64'h0);
        check_vec("async_no_write", 64'(mem_rr[8'h40]), 64'h0);
        reset = 1'b1;
        tick();
        check_vec("reserve_we",    64'(rr_mem_we),   64'h1);
        check_vec("reserve_addr",  64'(rr_mem_addr), 64'h40);
        check_vec("reserve_wd",    64'(rr_mem_wd),   64'hCAFE_0001);
        check_vec("reserve_grant", 64'(rr_grant),    64'h2);
        tick();
        check_vec("reserve_ready", 64'(rr_dma_ready),  64'h1);
        check_vec("reserve_we_lo", 64'(rr_mem_we),     64'h0);
        check_vec("reserve_mem",   64'(mem_rr[8'h40]), 64'hCAFE_0001);
        dma_req = 1'b0; dma_we = 1'b0;
        tick();
        check_vec("reserve_idle", 64'(rr_grant), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
